// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester: write-then-read-verify memory test over an AXI4 master.
// Software hands over base address, burst count and seed. The block writes an
// incrementing pattern, reads it back and compares every beat. Pass/fail,
// mismatch count and response-error status go back to the register slave.
module dram_pattern_tester #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_BURST_LEN        = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    // configuration from the register slave
    input  logic                              cfg_start,
    input  logic [31:0]                       cfg_base_addr,
    input  logic [15:0]                       cfg_num_bursts,
    input  logic [31:0]                       cfg_seed,
    // status back to the register slave
    output logic                              sts_busy,
    output logic                              sts_done,
    output logic                              sts_pass,
    output logic [15:0]                       sts_err_count,
    output logic                              sts_resp_err,
    // AXI4 write address channel
    output logic [0:0]                        M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    // AXI4 write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    // AXI4 write response channel
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    // AXI4 read address channel
    output logic [0:0]                        M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // AXI4 read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [7:0]  BEAT_LAST  = 8'(C_BURST_LEN - 1);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFE0;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_FINISH
    } state_t;

    state_t                          state_q, state_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            pass_q, pass_d;
    logic [15:0]                     err_cnt_q, err_cnt_d;
    logic                            resp_err_q, resp_err_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            wlast_q, wlast_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    // addr_q is the current burst address; data_q is the current pattern
    // word, used as WDATA while writing and as the expected word while reading
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]                      beat_q, beat_d;
    logic [15:0]                     burst_q, burst_d;
    logic [15:0]                     num_bursts_q, num_bursts_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   seed_q, seed_d;

    logic last_burst;
    assign last_burst = (burst_q == num_bursts_q - 16'd1);

    // State and every registered output; reset clears all of them at once
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            resp_err_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            num_bursts_q <= '0;
            base_q       <= '0;
            seed_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            resp_err_q   <= resp_err_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            beat_q       <= beat_d;
            burst_q      <= burst_d;
            num_bursts_q <= num_bursts_d;
            base_q       <= base_d;
            seed_q       <= seed_d;
        end
    end

    // Next-state and next-output logic for the test sequencer
    always_comb begin
        // NOTE: every target starts from its held value, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        resp_err_d   = resp_err_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        wlast_d      = wlast_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        addr_d       = addr_q;
        data_d       = data_q;
        beat_d       = beat_q;
        burst_d      = burst_q;
        num_bursts_d = num_bursts_q;
        base_d       = base_q;
        seed_d       = seed_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    base_d       = C_M_AXI_ADDR_WIDTH'(cfg_base_addr & ALIGN_MASK);
                    addr_d       = C_M_AXI_ADDR_WIDTH'(cfg_base_addr & ALIGN_MASK);
                    num_bursts_d = cfg_num_bursts;
                    seed_d       = C_M_AXI_DATA_WIDTH'(cfg_seed);
                    data_d       = C_M_AXI_DATA_WIDTH'(cfg_seed);
                    beat_d       = '0;
                    burst_d      = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    resp_err_d   = 1'b0;
                    busy_d       = 1'b1;
                    if (cfg_num_bursts == 16'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        awvalid_d = 1'b1;
                        state_d   = S_WR_ADDR;
                    end
                end
            end

            S_WR_ADDR: begin
                if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (BEAT_LAST == 8'd0);
                    state_d   = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                if (M_AXI_WREADY) begin
                    data_d = data_q + 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        beat_d   = '0;
                        state_d  = S_WR_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wlast_d = (beat_q + 8'd1 == BEAT_LAST);
                    end
                end
            end

            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        resp_err_d = 1'b1;
                    end
                    if (last_burst) begin
                        // rewind address and pattern for the verify pass
                        burst_d   = '0;
                        addr_d    = base_q;
                        data_d    = seed_q;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end else begin
                        burst_d   = burst_q + 16'd1;
                        addr_d    = addr_q + BURST_BYTES;
                        awvalid_d = 1'b1;
                        state_d   = S_WR_ADDR;
                    end
                end
            end

            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    data_d = data_q + 1'b1;
                    if (M_AXI_RDATA != data_q && err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    // a misplaced or missing RLAST is a protocol error, but
                    // the burst length stays fixed regardless
                    if (M_AXI_RRESP != 2'b00 ||
                        M_AXI_RLAST != (beat_q == BEAT_LAST)) begin
                        resp_err_d = 1'b1;
                    end
                    if (beat_q == BEAT_LAST) begin
                        beat_d   = '0;
                        rready_d = 1'b0;
                        if (last_burst) begin
                            state_d = S_FINISH;
                        end else begin
                            burst_d   = burst_q + 16'd1;
                            addr_d    = addr_q + BURST_BYTES;
                            arvalid_d = 1'b1;
                            state_d   = S_RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 16'd0) && !resp_err_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign sts_busy      = busy_q;
    assign sts_done      = done_q;
    assign sts_pass      = pass_q;
    assign sts_err_count = err_cnt_q;
    assign sts_resp_err  = resp_err_q;

    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = BEAT_LAST;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;

    assign M_AXI_BREADY  = bready_q;

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = BEAT_LAST;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_q;

    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Testbench for dram_pattern_tester: AXI slave memory model, scoreboard queues
// filled from a pattern model at test launch, and monitors that pop and compare.
module tb_dram_pattern_tester;

    localparam int BL = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_start;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_num_bursts;
    logic [31:0] cfg_seed;
    logic        sts_busy, sts_done, sts_pass, sts_resp_err;
    logic [15:0] sts_err_count;
    logic [0:0]  AWID, ARID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    dram_pattern_tester dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_pass(sts_pass),
        .sts_err_count(sts_err_count), .sts_resp_err(sts_resp_err),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
        .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
        .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic        resp_err;
    } sts_t;

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_w_q[$];
    sts_t        exp_sts_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic flush_queues();
        exp_aw_q.delete();
        exp_ar_q.delete();
        exp_w_q.delete();
        exp_sts_q.delete();
    endtask

    // ---------------- slave memory model and AXI monitor ----------------
    logic [31:0] mem [logic [31:0]];
    bit          rand_mode = 1'b0;
    int          bresp_err_burst = -1;
    int          b_burst_idx = 0;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    int          aw_total = 0, ar_total = 0, w_total = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [31:0] wr_addr, rd_addr, aw_st_addr, ar_st_addr, w_st_data;
        int          w_beat, r_beat, r_left, b_pending;
        bit          b_hs, r_hs, aw_st, ar_st, w_st, w_st_last;
        wr_addr = '0; rd_addr = '0; aw_st_addr = '0; ar_st_addr = '0; w_st_data = '0;
        w_beat = 0; r_beat = 0; r_left = 0; b_pending = 0;
        b_hs = 0; r_hs = 0; aw_st = 0; ar_st = 0; w_st = 0; w_st_last = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
                w_beat = 0; r_left = 0; r_beat = 0; b_pending = 0;
                b_hs = 0; r_hs = 0; aw_st = 0; ar_st = 0; w_st = 0;
                continue;
            end
            if (b_hs) begin BVALID = 0; b_hs = 0; end
            if (r_hs) begin RVALID = 0; RLAST = 0; r_hs = 0; end
            AWREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            WREADY  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            ARREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!BVALID && b_pending > 0) begin
                BVALID = 1;
                BRESP  = (b_burst_idx == bresp_err_burst) ? 2'b10 : 2'b00;
            end
            if (!RVALID && r_left > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                RVALID = 1;
                RDATA  = rd_word(rd_addr + 32'(4 * r_beat));
                RLAST  = (r_beat == BL - 1);
                RRESP  = 2'b00;
            end
            #1;
            // a stall on the previous edge must leave valid and payload untouched
            if (aw_st) begin
                check("aw_stall_valid", 64'(AWVALID), 64'(1));
                check("aw_stall_addr", 64'(AWADDR), 64'(aw_st_addr));
            end
            if (w_st) begin
                check("w_stall_valid", 64'(WVALID), 64'(1));
                check("w_stall_payload", {31'd0, WLAST, WDATA}, {31'd0, w_st_last, w_st_data});
            end
            if (ar_st) begin
                check("ar_stall_valid", 64'(ARVALID), 64'(1));
                check("ar_stall_addr", 64'(ARADDR), 64'(ar_st_addr));
            end
            aw_st = AWVALID && !AWREADY; aw_st_addr = AWADDR;
            w_st  = WVALID && !WREADY;   w_st_data = WDATA; w_st_last = WLAST;
            ar_st = ARVALID && !ARREADY; ar_st_addr = ARADDR;

            if (AWVALID && AWREADY) begin
                aw_total++;
                if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(AWADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("aw_addr", 64'(AWADDR), 64'(exp_aw_q.pop_front()));
                check("aw_attrs", 64'({AWID, AWLEN, AWSIZE, AWBURST}), 64'({1'b0, 8'd7, 3'b010, 2'b01}));
                wr_addr = AWADDR;
                w_beat  = 0;
            end
            if (WVALID && WREADY) begin
                w_total++;
                if (exp_w_q.size() == 0) check("w_unexpected", 64'(WDATA), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("w_data", 64'(WDATA), 64'(exp_w_q.pop_front()));
                check("w_last_strb", 64'({WLAST, WSTRB}), 64'({w_beat == BL - 1, 4'hF}));
                mem[wr_addr + 32'(4 * w_beat)] = WDATA;
                if (w_beat == BL - 1) begin b_pending++; w_beat = 0; end
                else w_beat++;
            end
            if (BVALID && BREADY) begin
                b_hs = 1; b_pending--; b_burst_idx++;
            end
            if (ARVALID && ARREADY) begin
                ar_total++;
                if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(ARADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("ar_addr", 64'(ARADDR), 64'(exp_ar_q.pop_front()));
                check("ar_attrs", 64'({ARID, ARLEN, ARSIZE, ARBURST}), 64'({1'b0, 8'd7, 3'b010, 2'b01}));
                if (corrupt_en) begin
                    mem[corrupt_addr] = rd_word(corrupt_addr) ^ 32'h0000_0100;
                    corrupt_en = 0;
                end
                rd_addr = ARADDR; r_left = BL; r_beat = 0;
            end
            if (RVALID && RREADY) begin
                r_hs = 1; r_left--; r_beat++;
            end
        end
    end

    // status monitor: each rising sts_done pops one expected status
    initial begin
        logic done_prev;
        sts_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge ACLK);
            if (sts_done && !done_prev) begin
                if (exp_sts_q.size() == 0) begin
                    check("sts_unexpected_done", 64'(sts_done), 64'(0));
                end else begin
                    e = exp_sts_q.pop_front();
                    check("sts_pass", 64'(sts_pass), 64'(e.pass));
                    check("sts_err_count", 64'(sts_err_count), 64'(e.err));
                    check("sts_resp_err", 64'(sts_resp_err), 64'(e.resp_err));
                    check("sts_busy_at_done", 64'(sts_busy), 64'(0));
                end
            end
            done_prev = sts_done;
        end
    end

    // ---------------- reference model and stimulus ----------------
    task automatic start_test(input logic [31:0] base, input int n, input logic [31:0] seed,
                              input bit rmode, input int berr, input bit corr,
                              input logic [31:0] caddr);
        logic [31:0] b;
        sts_t        e;
        b = base & 32'hFFFF_FFE0;
        for (int i = 0; i < n; i++) begin
            exp_aw_q.push_back(b + 32'(32 * i));
            exp_ar_q.push_back(b + 32'(32 * i));
        end
        for (int k = 0; k < 8 * n; k++) exp_w_q.push_back(seed + 32'(k));
        // a corrupted word inside the tested window is exactly one mismatch
        e.err      = (corr && ((caddr - b) < 32'(32 * n)) && caddr[1:0] == 2'b00) ? 16'd1 : 16'd0;
        e.resp_err = (berr >= 0) && (berr < n);
        e.pass     = (e.err == 16'd0) && !e.resp_err;
        exp_sts_q.push_back(e);
        rand_mode       = rmode;
        bresp_err_burst = berr;
        b_burst_idx     = 0;
        corrupt_en      = corr;
        corrupt_addr    = caddr;
        @(negedge ACLK);
        cfg_base_addr  = base;
        cfg_num_bursts = 16'(n);
        cfg_seed       = seed;
        cfg_start      = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
        check("start_busy", 64'(sts_busy), 64'(1));
        check("start_awvalid", 64'(AWVALID), 64'(n != 0));
    endtask

    task automatic finish_test(input int max_cyc, output int cycles);
        int cyc;
        cyc = 1;
        while (!sts_done && cyc < max_cyc) begin
            @(negedge ACLK);
            cyc++;
        end
        cycles = cyc;
        if (!sts_done) check("done_timeout", 64'(0), 64'(1));
        @(negedge ACLK);
        check("aw_drained", 64'(exp_aw_q.size()), 64'(0));
        check("ar_drained", 64'(exp_ar_q.size()), 64'(0));
        check("w_drained", 64'(exp_w_q.size()), 64'(0));
        check("sts_drained", 64'(exp_sts_q.size()), 64'(0));
        flush_queues();
    endtask

    initial begin
        int cycles, aw0, ar0, w0;
        ARESET = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_bursts = '0; cfg_seed = '0;
        #3;
        check("reset_ctrl", 64'({sts_busy, sts_done, sts_pass, sts_err_count, sts_resp_err,
              AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY}), 64'(0));
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;

        // basic pass, zero-wait
        start_test(32'h0000_0000, 4, 32'h0000_0001, 0, -1, 0, '0);
        finish_test(2000, cycles);
        for (int i = 0; i < 32; i++)
            check("basic_mem", 64'(rd_word(32'(4 * i))), 64'(i + 1));

        // N=1 timing bound, zero-wait
        start_test(32'h0000_0200, 1, 32'h1234_5678, 0, -1, 0, '0);
        finish_test(2000, cycles);
        check("n1_within_24", 64'(cycles <= 24), 64'(1));

        // injected mismatch between phases
        start_test(32'h0000_1000, 2, 32'hA5A5_0000, 0, -1, 1, 32'h0000_1014);
        finish_test(2000, cycles);

        // zero bursts: no address phases, done two cycles after start
        aw0 = aw_total; ar0 = ar_total;
        start_test(32'h0000_3000, 0, 32'h5555_0000, 0, -1, 0, '0);
        finish_test(2000, cycles);
        check("zero_latency", 64'(cycles), 64'(2));
        check("zero_no_aw", 64'(aw_total), 64'(aw0));
        check("zero_no_ar", 64'(ar_total), 64'(ar0));

        // backpressure with wrapping data
        start_test(32'h0000_4000, 3, 32'hFFFF_FFFE, 1, -1, 0, '0);
        finish_test(4000, cycles);

        // SLVERR on burst 1 of 2, plus an ignored start mid-test
        start_test(32'h0000_5000, 2, 32'h0BAD_0000, 0, 1, 0, '0);
        repeat (6) @(negedge ACLK);
        cfg_base_addr = 32'h0000_8000; cfg_num_bursts = 16'd1; cfg_seed = 32'h7777_7777;
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
        check("ignored_start_busy", 64'(sts_busy), 64'(1));
        finish_test(2000, cycles);

        // reset during write beat 3, then a clean run
        w0 = w_total;
        start_test(32'h0000_6000, 2, 32'h0000_0100, 0, -1, 0, '0);
        cycles = 0;
        while (w_total - w0 != 3 && cycles < 200) begin
            @(posedge ACLK);
            #2;
            cycles++;
        end
        check("reached_beat3", 64'(w_total - w0), 64'(3));
        check("beat3_wvalid", 64'(WVALID), 64'(1));
        ARESET = 1'b1;
        #1;
        check("midreset_ctrl", 64'({sts_busy, sts_done, sts_pass, sts_err_count, sts_resp_err,
              AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY}), 64'(0));
        check("midreset_payload", {AWADDR, WDATA}, 64'(0));
        flush_queues();
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        start_test(32'h0000_6000, 2, 32'h0000_0100, 1, -1, 0, '0);
        finish_test(4000, cycles);

        // randomized configurations under random backpressure
        for (int t = 0; t < 4; t++) begin
            start_test($urandom, int'($urandom_range(1, 3)), $urandom, 1, -1, 0, '0);
            finish_test(4000, cycles);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
